// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the core's data port.
// Provides a combinational word read, byte-lane-merged writes and a show-ahead
// write-log FIFO that records every accepted write as {pc, word address, merged word}.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LOG_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_pc,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    output logic                         addr_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Lane-wise merge of the stored word with lane-aligned write data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [31:0]      fifo_pc_r   [LOG_DEPTH];
    logic [31:0]      fifo_addr_r [LOG_DEPTH];
    logic [31:0]      fifo_data_r [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             addr_err_r;

    logic [29:0]      word_idx_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic             in_range_s;
    logic             wr_req_s;
    logic             wr_accept_s;
    logic             wr_oor_s;
    logic [31:0]      old_word_s;
    logic [31:0]      merged_s;
    logic             fifo_nonempty_s;
    logic             fifo_full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             unused_addr_bits_s;

    assign word_idx_s         = m_data_addr[31:2];
    assign mem_idx_s          = word_idx_s[IDX_W-1:0];
    assign in_range_s         = (word_idx_s < 30'(DEPTH_WORDS));
    assign wr_req_s           = (m_data_byteen != 4'b0000);
    assign wr_accept_s        = wr_req_s && in_range_s;
    assign wr_oor_s           = wr_req_s && !in_range_s;
    assign unused_addr_bits_s = ^m_data_addr[1:0];

    // Addressed word (pre-edge contents); out-of-range addresses read as zero.
    always_comb begin
        old_word_s = 32'h0000_0000;
        if (in_range_s) begin
            old_word_s = mem_r[mem_idx_s];
        end else begin
            old_word_s = 32'h0000_0000;
        end
    end

    assign merged_s     = merge_lanes(old_word_s, m_data_wdata, m_data_byteen);
    assign m_data_rdata = old_word_s;

    // A pop needs a valid head, so a push into an empty FIFO is never paired with a pop.
    // A full FIFO accepts a push only when the head leaves in the same cycle.
    assign fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
    assign fifo_full_s     = (count_r == CNT_W'(LOG_DEPTH));
    assign pop_s           = fifo_nonempty_s && log_ready;
    assign push_s          = wr_accept_s && (!fifo_full_s || pop_s);
    assign drop_s          = wr_accept_s && fifo_full_s && !pop_s;

    // Memory array: cleared on reset, otherwise takes the merged word on an accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (wr_accept_s) begin
            mem_r[mem_idx_s] <= merged_s;
        end
    end

    // Log record storage; emptiness is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= m_inst_addr;
            fifo_addr_r[wr_ptr_r] <= {word_idx_s, 2'b00};
            fifo_data_r[wr_ptr_r] <= merged_s;
        end
    end

    // Log FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= overflow_r || drop_s;
        end
    end

    // One-cycle error pulse following an out-of-range write attempt.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= wr_oor_s;
        end
    end

    assign log_valid    = fifo_nonempty_s;
    assign log_pc       = fifo_pc_r[rd_ptr_r];
    assign log_addr     = fifo_addr_r[rd_ptr_r];
    assign log_data     = fifo_data_r[rd_ptr_r];
    assign log_count    = count_r;
    assign log_overflow = overflow_r;
    assign addr_err     = addr_err_r;

endmodule
